// File: rtl/srt_div_pkg.sv
// Shared types and constants for the SRT divider control slice.
package srt_div_pkg;

  localparam int unsigned ITERATIONS_DEFAULT = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SP_NONE = 3'd0,
    SP_ZERO = 3'd1,
    SP_INF  = 3'd2,
    SP_DIV0 = 3'd3,
    SP_NAN  = 3'd4
  } special_t;

endpackage

// File: rtl/srt_special_detect.sv
// Combinational IEEE-754 single-precision special-case classifier for a/b.
module srt_special_detect
  import srt_div_pkg::*;
(
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output special_t    o_special
);

  logic w_a_exp_max, w_a_exp_min, w_a_man_nz;
  logic w_b_exp_max, w_b_exp_min, w_b_man_nz;
  logic w_a_nan, w_a_inf, w_a_zero;
  logic w_b_nan, w_b_inf, w_b_zero;

  assign w_a_exp_max = (i_dividend[30:23] == '1);
  assign w_a_exp_min = (i_dividend[30:23] == '0);
  assign w_a_man_nz  = (i_dividend[22:0] != '0);
  assign w_b_exp_max = (i_divisor[30:23] == '1);
  assign w_b_exp_min = (i_divisor[30:23] == '0);
  assign w_b_man_nz  = (i_divisor[22:0] != '0);

  // Denormals (min exponent, nonzero mantissa) fall through as finite nonzero.
  assign w_a_nan  = w_a_exp_max &  w_a_man_nz;
  assign w_a_inf  = w_a_exp_max & ~w_a_man_nz;
  assign w_a_zero = w_a_exp_min & ~w_a_man_nz;
  assign w_b_nan  = w_b_exp_max &  w_b_man_nz;
  assign w_b_inf  = w_b_exp_max & ~w_b_man_nz;
  assign w_b_zero = w_b_exp_min & ~w_b_man_nz;

  always_comb begin
    o_special = SP_NONE;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
      o_special = SP_NAN;
    else if (w_b_zero && !w_a_zero && !w_a_inf)
      o_special = SP_DIV0;
    else if (w_a_inf)
      o_special = SP_INF;
    else if (w_a_zero || w_b_inf)
      o_special = SP_ZERO;
  end

endmodule

// File: rtl/srt_div_ctrl.sv
// SRT floating-point divider sequencing controller (IDLE/LOAD/ITER/RESP).
// Optional abort input enabled by defining SRT_DIV_CTRL_ABORT_EN.
module srt_div_ctrl
  import srt_div_pkg::*;
#(
  parameter int unsigned ITERATIONS = ITERATIONS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SRT_DIV_CTRL_ABORT_EN
  input  logic        abort,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  output logic [31:0] op_dividend,
  output logic [31:0] op_divisor,
  output logic        dp_load,
  output logic        dp_step,
  output logic [4:0]  dp_iter_idx,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_special,
  output logic        rsp_sign,
  output logic        busy
);

  state_t     r_state, w_next;
  special_t   r_special, w_special;
  logic [31:0] r_op_a, r_op_b;
  logic       r_sign;
  logic [4:0] r_idx;
  logic       w_accept, w_abort, w_last;

`ifdef SRT_DIV_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  srt_special_detect u_detect (
    .i_dividend (req_dividend),
    .i_divisor  (req_divisor),
    .o_special  (w_special)
  );

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_last   = (r_idx == 5'(ITERATIONS - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_LOAD;
      ST_LOAD: w_next = (r_special == SP_NONE) ? ST_ITER : ST_RESP;
      ST_ITER: if (w_last) w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    // Abort overrides every non-idle transition, including the RESP handshake.
    if (w_abort && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_special <= SP_NONE;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_sign    <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op_a    <= req_dividend;
        r_op_b    <= req_divisor;
        r_sign    <= req_dividend[31] ^ req_divisor[31];
        r_special <= w_special;
      end
      if ((r_state == ST_ITER) && (w_next == ST_ITER))
        r_idx <= r_idx + 5'd1;
      else
        r_idx <= '0;
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign dp_load     = (r_state == ST_LOAD);
  assign dp_step     = (r_state == ST_ITER);
  assign dp_iter_idx = r_idx;
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_special = r_special;
  assign rsp_sign    = r_sign;
  assign op_dividend = r_op_a;
  assign op_divisor  = r_op_b;

endmodule

// File: tb/tb_srt_div_ctrl.sv
// Self-checking bench for srt_div_ctrl: directed cases plus randomized operands.
module tb_srt_div_ctrl;

  localparam int unsigned ITERS = 26;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_dividend = '0;
  logic [31:0] req_divisor = '0;
  logic [31:0] op_dividend, op_divisor;
  logic        dp_load, dp_step;
  logic [4:0]  dp_iter_idx;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_special;
  logic        rsp_sign;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  srt_div_ctrl #(.ITERATIONS(ITERS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef SRT_DIV_CTRL_ABORT_EN
    .abort        (abort),
`endif
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .op_dividend  (op_dividend),
    .op_divisor   (op_divisor),
    .dp_load      (dp_load),
    .dp_step      (dp_step),
    .dp_iter_idx  (dp_iter_idx),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_special  (rsp_special),
    .rsp_sign     (rsp_sign),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference classification: 0 NONE, 1 ZERO, 2 INF, 3 DIV0, 4 NAN.
  function automatic logic [2:0] ref_class(input logic [31:0] a, input logic [31:0] b);
    int  ea, eb;
    int  ma, mb;
    bit  an, ai, az, bn, bi, bz;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = int'(a[22:0]);  mb = int'(b[22:0]);
    an = (ea == 255) && (ma != 0); ai = (ea == 255) && (ma == 0); az = (ea == 0) && (ma == 0);
    bn = (eb == 255) && (mb != 0); bi = (eb == 255) && (mb == 0); bz = (eb == 0) && (mb == 0);
    if (an || bn || (az && bz) || (ai && bi)) return 3'd4;
    if (bz && !az && !ai) return 3'd3;
    if (ai) return 3'd2;
    if (az || bi) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [31:0] rand_op();
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom_range(1, 32'h7FFFFF));
    case ($urandom_range(0, 6))
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, m};
      3:       return {s, 8'h00, m};
      default: begin
        e = 8'($urandom_range(1, 254));
        return {s, e, m};
      end
    endcase
  endfunction

  // One full transaction; cycle 0 is the accept cycle, hold = extra RESP cycles with rsp_ready low.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int hold, input bit noise);
    logic [2:0] sp;
    int         lat;
    bit         stepping;
    sp  = ref_class(a, b);
    lat = (sp == 3'd0) ? int'(ITERS) + 2 : 2;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_dividend = a; req_divisor = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = noise;
    if (noise) begin req_dividend = ~a; req_divisor = ~b; end
    for (int c = 1; c <= lat + hold; c++) begin
      @(negedge clk);
      stepping = (sp == 3'd0) && (c >= 2) && (c <= int'(ITERS) + 1);
      check("dp_load",   32'(dp_load),     32'(c == 1));
      check("dp_step",   32'(dp_step),     32'(stepping));
      check("iter_idx",  32'(dp_iter_idx), stepping ? 32'(c - 2) : 32'd0);
      check("rsp_valid", 32'(rsp_valid),   32'(c >= lat));
      check("req_ready", 32'(req_ready),   32'd0);
      check("busy",      32'(busy),        32'd1);
      check("op_a",      op_dividend,      a);
      check("op_b",      op_divisor,       b);
      if (c >= lat) begin
        check("special", 32'(rsp_special), 32'(sp));
        check("sign",    32'(rsp_sign),    32'(a[31] ^ b[31]));
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("post_ready", 32'(req_ready), 32'd1);
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_load",  32'(dp_load),   32'd0);
    check("post_op_a",  op_dividend,    a);
  endtask

  task automatic start_and_reach_idx(input int idx);
    bit found;
    found = 1'b0;
    @(negedge clk);
    req_dividend = 32'h40C00000; req_divisor = 32'h40000000; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (dp_step && (int'(dp_iter_idx) == idx)) found = 1'b1;
    end
    check("reach_idx", 32'(found), 32'd1);
  endtask

  task automatic expect_idle_no_rsp(input string tag);
    bit seen;
    check({tag, "_ready"}, 32'(req_ready),   32'd1);
    check({tag, "_step"},  32'(dp_step),     32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_idx"},   32'(dp_iter_idx), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check({tag, "_no_rsp"}, 32'(seen), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready),   32'd1);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_load",  32'(dp_load),     32'd0);
    check("rst_step",  32'(dp_step),     32'd0);
    check("rst_idx",   32'(dp_iter_idx), 32'd0);
    check("rst_valid", 32'(rsp_valid),   32'd0);
    check("rst_sp",    32'(rsp_special), 32'd0);
    check("rst_sign",  32'(rsp_sign),    32'd0);
    check("rst_op_a",  op_dividend,      32'd0);
    check("rst_op_b",  op_divisor,       32'd0);
    rst_n = 1'b1;

    do_div(32'h40C00000, 32'h40000000, 0, 1'b0);
    do_div(32'h3F800000, 32'h00000000, 0, 1'b0);
    do_div(32'h00000000, 32'h00000000, 0, 1'b0);
    do_div(32'hBF800000, 32'h40000000, 5, 1'b1);
    do_div(32'h7F800000, 32'h3F800000, 0, 1'b0);
    do_div(32'h3F800000, 32'h7F800000, 1, 1'b1);
    do_div(32'h7F800000, 32'h00000000, 0, 1'b0);
    do_div(32'h00000001, 32'h00000000, 0, 1'b0);
    do_div(32'h7F800000, 32'hFF800000, 0, 1'b0);

    start_and_reach_idx(10);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_op_a", op_dividend, 32'd0);
    expect_idle_no_rsp("rst_mid");

`ifdef SRT_DIV_CTRL_ABORT_EN
    start_and_reach_idx(3);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    expect_idle_no_rsp("abort_iter");

    @(negedge clk);
    req_dividend = 32'h3F800000; req_divisor = 32'h00000000; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_resp_valid", 32'(rsp_valid), 32'd1);
    abort = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1 begin abort = 1'b0; rsp_ready = 1'b0; end
    @(negedge clk);
    expect_idle_no_rsp("abort_resp");

    abort = 1'b1;
    @(negedge clk);
    check("abort_idle_ready", 32'(req_ready), 32'd1);
    abort = 1'b0;
`endif

    for (int n = 0; n < 25; n++)
      do_div(rand_op(), rand_op(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/srt_div_ctrl.md
SRT_DIV_CTRL -- requirements
Module: srt_div_ctrl

Interface
REQ-001 SHALL have parameter ITERATIONS, default 26, giving the number of SRT iteration cycles per division (range 1..31).
REQ-002 SHALL have port clk, input, 1, the only clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, which qualifies a division request.
REQ-005 SHALL have port req_ready, output, 1, asserted when the controller can accept a request.
REQ-006 SHALL have ports req_dividend and req_divisor, input, 32 each, the IEEE-754 single-precision operands.
REQ-007 SHALL have ports op_dividend and op_divisor, output, 32 each, the captured operands, held stable to the datapath until the next accept.
REQ-008 SHALL have port dp_load, output, 1, a one-cycle pulse that makes the datapath load its normalized mantissas and exponent.
REQ-009 SHALL have port dp_step, output, 1, asserted for each SRT iteration cycle.
REQ-010 SHALL have port dp_iter_idx, output, 5, the index of the current iteration.
REQ-011 SHALL have port rsp_valid, output, 1, asserted while a result is presented.
REQ-012 SHALL have port rsp_ready, input, 1, the consumer's acceptance of a result.
REQ-013 SHALL have port rsp_special, output, 3, the special-case code: 0 NONE, 1 ZERO, 2 INF, 3 DIV0, 4 NAN.
REQ-014 SHALL have port rsp_sign, output, 1, the result sign (dividend[31] XOR divisor[31]).
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, ITER and RESP.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high on a clock edge.
REQ-018 SHALL, on accept, register the operands, rsp_sign and the classified special code, then go to LOAD.
REQ-019 SHALL assert dp_load only in LOAD, for exactly one cycle.
REQ-020 SHALL go from LOAD to ITER when the special code is NONE, otherwise directly to RESP with dp_step never asserted.
REQ-021 SHALL, in ITER, hold dp_step high and increment dp_iter_idx from 0 to ITERATIONS-1, one per cycle, then go to RESP.
REQ-022 SHALL, with accept at cycle 0, assert dp_load in cycle 1, dp_step in cycles 2..ITERATIONS+1 and rsp_valid from cycle ITERATIONS+2; a special case asserts rsp_valid from cycle 2.
REQ-023 SHALL hold rsp_valid, rsp_special and rsp_sign stable in RESP until rsp_ready is high, then return to IDLE; no request is accepted in that same cycle.
REQ-024 SHALL classify in priority order:
- NAN: either operand NaN, 0/0, or inf/inf.
- DIV0: divisor zero with a finite nonzero dividend.
- INF: infinite dividend.
- ZERO: zero dividend or infinite divisor.
- Denormals count as nonzero finite.
REQ-025 SHALL keep dp_iter_idx at 0 outside ITER.
REQ-026 SHALL ignore req_valid while busy, with no effect on captured state.

Reset
REQ-027 SHALL, while rst_n is low at a clock edge, force the FSM to IDLE and all outputs and registers to 0 except req_ready, which is 1 after reset.
REQ-028 SHALL let reset asserted in any state, including mid-ITER, abandon the operation with no rsp_valid produced.

Configuration
REQ-029 SHALL, when macro SRT_DIV_CTRL_ABORT_EN is defined, add input abort (1 bit), which returns the FSM to IDLE from LOAD, ITER or RESP on the next edge with no response.
REQ-030 SHALL let abort have no effect in IDLE, and SHALL let abort win over rsp_ready in RESP.
REQ-031 SHALL, when SRT_DIV_CTRL_ABORT_EN is undefined, have no abort port, and every accepted request completes.

Structure
REQ-032 SHALL place the state enum, the special-code enum and the ITERATIONS default constant in shared package srt_div_pkg.
REQ-033 SHALL implement the combinational classification in one sub-module, srt_special_detect.

Verification
REQ-034 SHALL cover: 0x40C00000 / 0x40000000, ITERATIONS=26 -> dp_load in cycle 1, dp_step for 26 cycles with idx 0..25, rsp_valid in cycle 28, special 0, sign 0.
REQ-035 SHALL cover: 0x3F800000 / 0x00000000 -> no dp_step, rsp_valid in cycle 2, special 3 (DIV0); 0x00000000 / 0x00000000 -> special 4 (NAN).
REQ-036 SHALL cover: 0xBF800000 / 0x40000000 with rsp_ready low for 5 cycles -> rsp_valid held 5+ cycles, sign 1, req_ready 0 throughout, req_valid ignored.
REQ-037 SHALL cover: rst_n low in the cycle with idx=10 -> next cycle IDLE, req_ready 1, dp_step 0, and no rsp_valid ever appears.
REQ-038 SHALL cover: 0x7F800000 / 0x3F800000 -> special 2 (INF); 0x3F800000 / 0x7F800000 -> special 1 (ZERO).
REQ-039 SHALL cover, with SRT_DIV_CTRL_ABORT_EN defined: abort at idx=3 -> IDLE next cycle, no rsp_valid; abort together with rsp_ready in RESP -> IDLE with no handshake counted.
